and3_cond_qualifier: RTL and testbench

- Sequential front end for the 3-input AND gating used on ND-120 control signals.
- Synchronises three asynchronous inputs and applies per-input bubble inversion.
- Forms their AND and qualifies the result: it must hold stable for QUAL_CYCLES consecutive clocks before a clean registered level and edge pulses go downstream.
- Replaces a raw combinational AND wherever asynchronous board signals feed microcode or bus logic.

---
 rtl/nd120_cond_pkg.sv | 14 +
 rtl/nd120_sync_ff.sv | 23 ++
 rtl/and3_cond_qualifier.sv | 150 +++++++++++++++
 tb/tb_and3_cond_qualifier.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nd120_cond_pkg.sv
// Shared types for the ND-120 condition qualifier: FSM state encoding and counter width.
// result is taken directly from state[1], so the encoding below is load-bearing.
package nd120_cond_pkg;

  localparam int QUAL_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    ARMING    = 2'b01,
    ACTIVE    = 2'b11,
    DISARMING = 2'b10
  } cond_state_e;

endpackage

// File: rtl/nd120_sync_ff.sv
// Single-bit multi-flop synchroniser for an asynchronous board signal.
module nd120_sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_reg <= '0;
    end else begin
      chain_reg <= {chain_reg[STAGES-2:0], d};
    end
  end

  assign q = chain_reg[STAGES-1];

endmodule

// File: rtl/and3_cond_qualifier.sv
// Synchronised, bubble-processed 3-input AND with consecutive-cycle qualification.
// Optional fall_pulse output is enabled by defining AND3_COND_FALL_PULSE_EN.
module and3_cond_qualifier
  import nd120_cond_pkg::*;
#(
  parameter logic [2:0] BUBBLES_MASK = 3'b000,
  parameter int         SYNC_STAGES  = 2,
  parameter int         QUAL_CYCLES  = 4
) (
  input  logic                  sysclk,
  input  logic                  sys_rst_n,
  input  logic                  enable,
  input  logic                  input1,
  input  logic                  input2,
  input  logic                  input3,
  output logic                  cond_sync,
  output logic                  result,
  output logic                  rise_pulse,
`ifdef AND3_COND_FALL_PULSE_EN
  output logic                  fall_pulse,
`endif
  output logic [QUAL_CNT_W-1:0] qual_cnt
);

  localparam logic [QUAL_CNT_W-1:0] QUAL_LIMIT = QUAL_CNT_W'(QUAL_CYCLES);
  localparam logic [QUAL_CNT_W-1:0] CNT_ONE    = QUAL_CNT_W'(1);

  logic [2:0] raw_bits;
  logic [2:0] sync_bits;

  assign raw_bits = {input3, input2, input1};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
      nd120_sync_ff #(
        .STAGES(SYNC_STAGES)
      ) u_sync (
        .clk  (sysclk),
        .rst_n(sys_rst_n),
        .d    (raw_bits[gi]),
        .q    (sync_bits[gi])
      );
    end
  endgenerate

  assign cond_sync = &(sync_bits ^ BUBBLES_MASK);

  cond_state_e           state_reg, state_next;
  logic [QUAL_CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
  logic                  rise_reg, rise_next;
`ifdef AND3_COND_FALL_PULSE_EN
  logic                  fall_reg, fall_next;
`endif

  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      rise_reg  <= 1'b0;
`ifdef AND3_COND_FALL_PULSE_EN
      fall_reg  <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      rise_reg  <= rise_next;
`ifdef AND3_COND_FALL_PULSE_EN
      fall_reg  <= fall_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    cnt_inc    = cnt_reg + CNT_ONE;
    if (!enable) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (cond_sync) begin
            if (QUAL_CYCLES == 1) begin
              state_next = ACTIVE;
            end else begin
              state_next = ARMING;
              cnt_next   = CNT_ONE;
            end
          end
        end
        ARMING: begin
          if (!cond_sync) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else if (cnt_inc == QUAL_LIMIT) begin
            state_next = ACTIVE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_inc;
          end
        end
        ACTIVE: begin
          if (!cond_sync) begin
            if (QUAL_CYCLES == 1) begin
              state_next = IDLE;
            end else begin
              state_next = DISARMING;
              cnt_next   = CNT_ONE;
            end
          end
        end
        DISARMING: begin
          if (cond_sync) begin
            state_next = ACTIVE;
            cnt_next   = '0;
          end else if (cnt_inc == QUAL_LIMIT) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_inc;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // Pulses are registered alongside state so they line up with the result change;
  // a forced clear (enable low) must not produce a fall pulse.
  always_comb begin
    rise_next = enable & ~state_reg[1] & state_next[1];
`ifdef AND3_COND_FALL_PULSE_EN
    fall_next = enable & state_reg[1] & ~state_next[1];
`endif
  end

  always_comb begin
    result     = state_reg[1];
    rise_pulse = rise_reg;
    qual_cnt   = cnt_reg;
`ifdef AND3_COND_FALL_PULSE_EN
    fall_pulse = fall_reg;
`endif
  end

endmodule

// File: tb/tb_and3_cond_qualifier.sv
// Bench for and3_cond_qualifier: three parameterisations, directed table, hand sequences, random vs model.
module tb_and3_cond_qualifier;

  logic       sysclk;
  logic       sys_rst_n;
  logic       enable;
  logic [2:0] din;

  logic       cs  [3];
  logic       res [3];
  logic       rp  [3];
  logic [7:0] qc  [3];
`ifdef AND3_COND_FALL_PULSE_EN
  logic       fp  [3];
`endif

  int total = 0;
  int bad   = 0;

  int         p_sync [3] = '{2, 2, 3};
  int         p_qual [3] = '{4, 4, 1};
  logic [2:0] p_mask [3] = '{3'b000, 3'b010, 3'b000};

  // Reference model: input history plus run length of disagreement with result.
  logic [2:0] hist   [3];
  bit         m_res  [3];
  bit         m_rise [3];
  bit         m_fall [3];
  int         m_run  [3];

  and3_cond_qualifier #(.BUBBLES_MASK(3'b000), .SYNC_STAGES(2), .QUAL_CYCLES(4)) u_dut (
    .sysclk(sysclk), .sys_rst_n(sys_rst_n), .enable(enable),
    .input1(din[0]), .input2(din[1]), .input3(din[2]),
    .cond_sync(cs[0]), .result(res[0]), .rise_pulse(rp[0]),
`ifdef AND3_COND_FALL_PULSE_EN
    .fall_pulse(fp[0]),
`endif
    .qual_cnt(qc[0]));

  and3_cond_qualifier #(.BUBBLES_MASK(3'b010), .SYNC_STAGES(2), .QUAL_CYCLES(4)) u_bub (
    .sysclk(sysclk), .sys_rst_n(sys_rst_n), .enable(enable),
    .input1(din[0]), .input2(din[1]), .input3(din[2]),
    .cond_sync(cs[1]), .result(res[1]), .rise_pulse(rp[1]),
`ifdef AND3_COND_FALL_PULSE_EN
    .fall_pulse(fp[1]),
`endif
    .qual_cnt(qc[1]));

  and3_cond_qualifier #(.BUBBLES_MASK(3'b000), .SYNC_STAGES(3), .QUAL_CYCLES(1)) u_q1 (
    .sysclk(sysclk), .sys_rst_n(sys_rst_n), .enable(enable),
    .input1(din[0]), .input2(din[1]), .input3(din[2]),
    .cond_sync(cs[2]), .result(res[2]), .rise_pulse(rp[2]),
`ifdef AND3_COND_FALL_PULSE_EN
    .fall_pulse(fp[2]),
`endif
    .qual_cnt(qc[2]));

  initial begin
    sysclk = 1'b0;
    forever #5 sysclk = ~sysclk;
  end

  function automatic bit cond_of(int d);
    return &(hist[p_sync[d]-1] ^ p_mask[d]);
  endfunction

  task automatic model_step();
    bit c;
    for (int d = 0; d < 3; d++) begin
      m_rise[d] = 1'b0;
      m_fall[d] = 1'b0;
      if (!sys_rst_n || !enable) begin
        m_res[d] = 1'b0;
        m_run[d] = 0;
      end else begin
        c = cond_of(d);
        if (c != m_res[d]) begin
          m_run[d]++;
          if (m_run[d] == p_qual[d]) begin
            m_res[d]  = ~m_res[d];
            m_run[d]  = 0;
            m_rise[d] = m_res[d];
            m_fall[d] = ~m_res[d];
          end
        end else begin
          m_run[d] = 0;
        end
      end
    end
    if (!sys_rst_n) begin
      for (int k = 0; k < 3; k++) hist[k] = 3'b000;
    end else begin
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = din;
    end
  endtask

  task automatic chk(string name, int d, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s dut%0d: got %0d want %0d at t=%0t", name, d, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    model_step();
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("cond_sync", d, int'(cs[d]), int'(cond_of(d)));
      chk("result", d, int'(res[d]), int'(m_res[d]));
      chk("rise_pulse", d, int'(rp[d]), int'(m_rise[d]));
      chk("qual_cnt", d, int'(qc[d]), m_run[d]);
`ifdef AND3_COND_FALL_PULSE_EN
      chk("fall_pulse", d, int'(fp[d]), int'(m_fall[d]));
`endif
    end
  endtask

  typedef struct {
    bit       rst_n;
    bit       en;
    bit [2:0] in;
    bit       cond;
    bit       res;
    bit       rise;
    int       cnt;
  } vec_t;

  function automatic vec_t mk(bit r, bit e, bit [2:0] i, bit c, bit q, bit p, int n);
    vec_t v;
    v.rst_n = r; v.en = e; v.in = i; v.cond = c; v.res = q; v.rise = p; v.cnt = n;
    return v;
  endfunction

  vec_t tbl[$];
  int   n_hi, n_rise, n_fall;

  initial begin
    sys_rst_n = 1'b0;
    enable    = 1'b1;
    din       = 3'b000;
    for (int d = 0; d < 3; d++) begin
      hist[d] = 3'b000; m_res[d] = 0; m_rise[d] = 0; m_fall[d] = 0; m_run[d] = 0;
    end

    // Reset, release latency, then a two-cycle input2 glitch on the default instance.
    tbl.push_back(mk(0, 1, 3'b111, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3'b111, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 3'b111, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 3'b111, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 3'b111, 1, 0, 0, 1));
    tbl.push_back(mk(1, 1, 3'b111, 1, 0, 0, 2));
    tbl.push_back(mk(1, 1, 3'b111, 1, 0, 0, 3));
    tbl.push_back(mk(1, 1, 3'b111, 1, 1, 1, 0));
    tbl.push_back(mk(1, 1, 3'b111, 1, 1, 0, 0));
    tbl.push_back(mk(1, 1, 3'b101, 1, 1, 0, 0));
    tbl.push_back(mk(1, 1, 3'b101, 0, 1, 0, 0));
    tbl.push_back(mk(1, 1, 3'b111, 0, 1, 0, 1));
    tbl.push_back(mk(1, 1, 3'b111, 1, 1, 0, 2));
    tbl.push_back(mk(1, 1, 3'b111, 1, 1, 0, 0));
    // Enable clear from ARMING at count 3, then full requalification.
    tbl.push_back(mk(0, 1, 3'b111, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 3'b111, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 3'b111, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 3'b111, 1, 0, 0, 1));
    tbl.push_back(mk(1, 1, 3'b111, 1, 0, 0, 2));
    tbl.push_back(mk(1, 1, 3'b111, 1, 0, 0, 3));
    tbl.push_back(mk(1, 0, 3'b111, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 3'b111, 1, 0, 0, 1));
    tbl.push_back(mk(1, 1, 3'b111, 1, 0, 0, 2));
    tbl.push_back(mk(1, 1, 3'b111, 1, 0, 0, 3));
    tbl.push_back(mk(1, 1, 3'b111, 1, 1, 1, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      sys_rst_n = tbl[i].rst_n;
      enable    = tbl[i].en;
      din       = tbl[i].in;
      tick();
      chk("tbl_cond", 0, int'(cs[0]), int'(tbl[i].cond));
      chk("tbl_result", 0, int'(res[0]), int'(tbl[i].res));
      chk("tbl_rise", 0, int'(rp[0]), int'(tbl[i].rise));
      chk("tbl_cnt", 0, int'(qc[0]), tbl[i].cnt);
    end

    // Bubble on input2: inputs 1,0,1 qualify, inputs 1,1,1 never do.
    enable = 1'b1; sys_rst_n = 1'b0; din = 3'b101;
    tick();
    sys_rst_n = 1'b1;
    tick();
    chk("bub_cond_e1", 1, int'(cs[1]), 0);
    tick();
    chk("bub_cond_e2", 1, int'(cs[1]), 1);
    repeat (3) tick();
    chk("bub_res_e5", 1, int'(res[1]), 0);
    tick();
    chk("bub_res_e6", 1, int'(res[1]), 1);
    sys_rst_n = 1'b0; din = 3'b111;
    tick();
    sys_rst_n = 1'b1;
    n_hi = 0;
    repeat (10) begin
      tick();
      n_hi += int'(res[1]);
    end
    chk("bub_hold_low", 1, n_hi, 0);

    // QUAL_CYCLES=1 / SYNC_STAGES=3: one-sample pulse passes straight through.
    sys_rst_n = 1'b0; din = 3'b000;
    tick();
    sys_rst_n = 1'b1; din = 3'b111;
    tick();
    din = 3'b000;
    n_hi = 0; n_rise = 0; n_fall = 0;
    repeat (8) begin
      tick();
      n_hi   += int'(res[2]);
      n_rise += int'(rp[2]);
`ifdef AND3_COND_FALL_PULSE_EN
      n_fall += int'(fp[2]);
`endif
    end
    chk("q1_res_cycles", 2, n_hi, 1);
    chk("q1_rise_count", 2, n_rise, 1);
`ifdef AND3_COND_FALL_PULSE_EN
    chk("q1_fall_count", 2, n_fall, 1);
`endif

    // Random traffic with sticky inputs, occasional enable drops and resets.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(3) == 0) begin
        din = ($urandom_range(1) == 1) ? 3'b111 : 3'($urandom_range(7));
      end
      enable    = ($urandom_range(29) != 0);
      sys_rst_n = ($urandom_range(79) != 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
